// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-clock enable
// Produces the scan address plus delayed sync/active so they align with downstream colour data.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [19:0] address,
  output logic        h_sync,
  output logic        v_sync,
  output logic        active,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PD      = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic [3*PD-1:0]  pipe_q, pipe_d;
  logic [2:0]       raw, del;
  logic             tick, h_wrap;

  logic        pix_en_q, line_start_q, frame_start_q;
  logic [19:0] address_q;
  logic        h_sync_q, v_sync_q, active_q;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    h_wrap    = (hcount_q == H_LAST);
    hcount_d  = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d  = vcount_q;
    if (h_wrap) vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    // Raw terms are taken from the post-tick position so they match the address register.
    raw[2] = (hcount_d >= HS_BEG) && (hcount_d < HS_END);
    raw[1] = (vcount_d >= VS_BEG) && (vcount_d < VS_END);
    raw[0] = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    pipe_d = (3*PD)'({pipe_q, raw});
    del    = (SYNC_DELAY == 0) ? raw : pipe_q[3*PD-1 -: 3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      pipe_q        <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      address_q     <= 20'd0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      active_q      <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= tick;
      line_start_q  <= tick && (hcount_d == 10'd0);
      frame_start_q <= tick && (hcount_d == 10'd0) && (vcount_d == 10'd0);
      if (tick) begin
        hcount_q  <= hcount_d;
        vcount_q  <= vcount_d;
        address_q <= {vcount_d, hcount_d};
        pipe_q    <= pipe_d;
        h_sync_q  <= del[2] ? SYNC_POL : ~SYNC_POL;
        v_sync_q  <= del[1] ? SYNC_POL : ~SYNC_POL;
        active_q  <= del[0];
      end
    end
  end

  assign pix_en      = pix_en_q;
  assign address     = address_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three configurations
module tb_vga_timing_gen;

  localparam int ND = 3;
  localparam int CD_P  [ND] = '{4, 1, 2};
  localparam int D_P   [ND] = '{2, 0, 1};
  localparam int POL_P [ND] = '{0, 1, 0};
  localparam int HA_P  [ND] = '{640, 8, 6};
  localparam int HF_P  [ND] = '{16, 2, 1};
  localparam int HS_P  [ND] = '{96, 3, 2};
  localparam int HB_P  [ND] = '{48, 2, 1};
  localparam int VA_P  [ND] = '{480, 4, 3};
  localparam int VF_P  [ND] = '{10, 1, 1};
  localparam int VS_P  [ND] = '{2, 2, 1};
  localparam int VB_P  [ND] = '{33, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ND-1:0] pix_en_w, hs_w, vs_w, act_w, ls_w, fs_w;
  logic [19:0]   addr_w [ND];

  int  e = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  running = 1'b0;
  logic [24:0] sb_q [ND][$];
  logic [24:0] hold_exp [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV(CD_P[g]), .H_ACTIVE(HA_P[g]), .H_FP(HF_P[g]), .H_SYNC(HS_P[g]), .H_BP(HB_P[g]),
      .V_ACTIVE(VA_P[g]), .V_FP(VF_P[g]), .V_SYNC(VS_P[g]), .V_BP(VB_P[g]),
      .SYNC_POL(POL_P[g] != 0), .SYNC_DELAY(D_P[g])
    ) u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en_w[g]), .address(addr_w[g]),
      .h_sync(hs_w[g]), .v_sync(vs_w[g]), .active(act_w[g]),
      .line_start(ls_w[g]), .frame_start(fs_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] reset_vec(int k);
    logic pol;
    pol = (POL_P[k] != 0);
    return {20'd0, 1'b0, 1'b0, ~pol, ~pol, 1'b0};
  endfunction

  // Reference: tick n places the raster at linear position n mod frame; delayed terms come from tick n-D.
  function automatic logic [24:0] model(int k, int n);
    int ht, vt, pos, hc, vc, p2, h2, v2;
    logic h, v, a, pol;
    ht = HA_P[k] + HF_P[k] + HS_P[k] + HB_P[k];
    vt = VA_P[k] + VF_P[k] + VS_P[k] + VB_P[k];
    pos = n % (ht * vt);
    hc = pos % ht;
    vc = pos / ht;
    h = 1'b0; v = 1'b0; a = 1'b0;
    if (n - D_P[k] >= 1) begin
      p2 = (n - D_P[k]) % (ht * vt);
      h2 = p2 % ht;
      v2 = p2 / ht;
      h = (h2 >= HA_P[k] + HF_P[k]) && (h2 < HA_P[k] + HF_P[k] + HS_P[k]);
      v = (v2 >= VA_P[k] + VF_P[k]) && (v2 < VA_P[k] + VF_P[k] + VS_P[k]);
      a = (h2 < HA_P[k]) && (v2 < VA_P[k]);
    end
    pol = (POL_P[k] != 0);
    return {10'(vc), 10'(hc), hc == 0, pos == 0, h ? pol : ~pol, v ? pol : ~pol, a};
  endfunction

  function automatic logic [24:0] observed(int k);
    return {addr_w[k], ls_w[k], fs_w[k], hs_w[k], vs_w[k], act_w[k]};
  endfunction

  always @(posedge clk) begin
    if (running) begin
      e++;
      for (int k = 0; k < ND; k++)
        if (e % CD_P[k] == 0) sb_q[k].push_back(model(k, e / CD_P[k]));
    end
  end

  always @(negedge clk) begin
    if (running && e > 0) begin
      for (int k = 0; k < ND; k++) begin
        logic [24:0] exp_v;
        check($sformatf("dut%0d pix_en e=%0d", k, e), 32'(pix_en_w[k]), 32'(e % CD_P[k] == 0));
        if (pix_en_w[k]) begin
          if (sb_q[k].size() == 0) begin
            check($sformatf("dut%0d sb_underflow e=%0d", k, e), 32'(sb_q[k].size()), 32'd1);
          end else begin
            exp_v = sb_q[k].pop_front();
            check($sformatf("dut%0d tick e=%0d", k, e), 32'(observed(k)), 32'(exp_v));
            hold_exp[k] = {exp_v[24:5], 2'b00, exp_v[2:0]};
          end
        end else begin
          check($sformatf("dut%0d hold e=%0d", k, e), 32'(observed(k)), 32'(hold_exp[k]));
        end
      end
    end
  end

  task automatic check_reset(input string when);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("dut%0d %s outputs", k, when), 32'(observed(k)), 32'(reset_vec(k)));
      check($sformatf("dut%0d %s pix_en", k, when), 32'(pix_en_w[k]), 32'd0);
    end
  endtask

  task automatic drain(input string when);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("dut%0d %s sb_left", k, when), 32'(sb_q[k].size()), 32'd0);
      sb_q[k].delete();
    end
  endtask

  task automatic release_reset();
    for (int k = 0; k < ND; k++) hold_exp[k] = reset_vec(k);
    e = 0;
    #1;
    rst = 1'b1;
    running = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    release_reset();
    repeat (7000) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    running = 1'b0;
    #1;
    check_reset("async");
    drain("pre_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("held");
    release_reset();
    repeat (4000) @(posedge clk);
    @(negedge clk);
    #1;
    drain("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
